// File: rtl/status_reporter_pkg.sv
// Shared definitions for the status frame reporter: FSM encoding, frame lengths, framing bytes.
// Frame length depends on STATUS_REPORTER_CHECKSUM_EN.
package status_reporter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StAck,
        StDrain,
        StFinish
    } state_e;

    localparam int unsigned FrameLenPlain = 12;
    localparam int unsigned FrameLenCsum  = 13;

`ifdef STATUS_REPORTER_CHECKSUM_EN
    localparam int unsigned FrameLen = FrameLenCsum;
`else
    localparam int unsigned FrameLen = FrameLenPlain;
`endif

    localparam logic [7:0] DefaultHeader  = 8'h3E;
    localparam logic [7:0] DefaultTrailer = 8'h0A;

    // XOR of the mode byte and all nine intensity bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0]  mode,
                                                  input logic [71:0] ints);
        logic [7:0] c;
        c = mode;
        for (int i = 0; i < 9; i++) begin
            c = c ^ ints[8*i +: 8];
        end
        return c;
    endfunction

endpackage

// File: rtl/status_byte_mux.sv
// Selects the frame byte for a given byte index from the snapshot.
// Checksum byte only exists when STATUS_REPORTER_CHECKSUM_EN is defined.
module status_byte_mux
    import status_reporter_pkg::*;
#(
    parameter logic [7:0] HEADER  = DefaultHeader,
    parameter logic [7:0] TRAILER = DefaultTrailer
) (
    input  logic [3:0]  idx_i,
    input  logic [7:0]  mode_i,
    input  logic [71:0] intensities_i,
    output logic [7:0]  byte_o
);

`ifdef STATUS_REPORTER_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = frame_checksum(mode_i, intensities_i);
`endif

    always_comb begin
        byte_o = TRAILER;
        case (idx_i)
            4'd0:    byte_o = HEADER;
            4'd1:    byte_o = mode_i;
            4'd2:    byte_o = intensities_i[71:64];
            4'd3:    byte_o = intensities_i[63:56];
            4'd4:    byte_o = intensities_i[55:48];
            4'd5:    byte_o = intensities_i[47:40];
            4'd6:    byte_o = intensities_i[39:32];
            4'd7:    byte_o = intensities_i[31:24];
            4'd8:    byte_o = intensities_i[23:16];
            4'd9:    byte_o = intensities_i[15:8];
            4'd10:   byte_o = intensities_i[7:0];
`ifdef STATUS_REPORTER_CHECKSUM_EN
            4'd11:   byte_o = csum;
`endif
            default: byte_o = TRAILER;
        endcase
    end

endmodule

// File: rtl/status_reporter.sv
// Emits one status frame (header, mode, 9 intensity bytes, trailer) over a UART handshake.
// Define STATUS_REPORTER_CHECKSUM_EN to insert an XOR checksum byte before the trailer.
module status_reporter
    import status_reporter_pkg::*;
#(
    parameter logic [7:0] HEADER  = DefaultHeader,
    parameter logic [7:0] TRAILER = DefaultTrailer
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [7:0]  mode,
    input  logic [71:0] intensities,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LastIdx = 4'(FrameLen - 1);

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  mode_q;
    logic [71:0] int_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  frame_byte;

    status_byte_mux #(
        .HEADER  (HEADER),
        .TRAILER (TRAILER)
    ) u_byte_mux (
        .idx_i         (idx_q),
        .mode_i        (mode_q),
        .intensities_i (int_q),
        .byte_o        (frame_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            mode_q     <= 8'h00;
            int_q      <= 72'h0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        mode_q  <= mode;
                        int_q   <= intensities;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (!tx_busy) begin
                        tx_data_q  <= frame_byte;
                        tx_start_q <= 1'b1;
                        state_q    <= StAck;
                    end
                end
                // Wait for the transmitter to acknowledge the launch before draining.
                StAck: begin
                    if (tx_busy) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!tx_busy) begin
                        if (idx_q == LastIdx) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFinish;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= StSend;
                        end
                    end
                end
                StFinish: begin
                    idx_q   <= 4'd0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
